byte_packer: RTL and testbench

Downstream consumer of the byte-extract stage's registered output: takes the qualified 32-bit words whose low byte carries the payload, packs four consecutive bytes into one 32-bit word, and buffers packed words in a small FIFO behind a valid/ready output. It sits between the clocking-block byte stage and any word-wide sink. It absorbs sink back-pressure and reports loss, because the upstream stage cannot be stalled.

---
 rtl/byte_packer.sv | 83 ++++++++
 tb/tb_byte_packer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/byte_packer.sv
// byte_packer: packs qualified bytes into little-endian 32-bit words and queues them in a FWFT FIFO.
// Optional BYTE_PACKER_PARITY_EN adds out_par, the per-lane even parity stored with each word.
module byte_packer #(
  parameter int DEPTH = 4
) (
  input  logic                       ck,
  input  logic                       rst_n,
  input  logic                       enin,
  input  logic [31:0]                din,
  input  logic                       flush,
  input  logic                       ovf_clr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_data,
  output logic [3:0]                 out_keep,
`ifdef BYTE_PACKER_PARITY_EN
  output logic [3:0]                 out_par,
`endif
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);
  logic [1:0] idx;
  logic [23:0] hold;
  logic [AW-1:0] wp, rp;
  logic [31:0] mem_d [DEPTH];
  logic [3:0] mem_k [DEPTH];
  logic [31:0] word;
  logic [3:0] keep;
  logic [2:0] n;
  logic push, pop, acc;
  // Lanes beyond idx in hold are always zero, so the merged word needs no masking
  always_comb begin
    word = {8'd0, hold};
    if (enin) word[{idx, 3'b000} +: 8] = din[7:0];
    n = {1'b0, idx} + {2'b00, enin};
    keep = n[2] ? 4'hf : 4'((4'd1 << n) - 4'd1);
    push = (enin && idx == 2'd3) || (flush && n != 3'd0);
  end
  assign out_valid = level != '0;
  assign pop = out_valid && out_ready;
  assign acc = push && (level != FULL || pop);
  assign out_data = out_valid ? mem_d[rp] : '0;
  assign out_keep = out_valid ? mem_k[rp] : '0;
  always_ff @(posedge ck or negedge rst_n)
    if (!rst_n) begin
      idx <= '0;
      hold <= '0;
      wp <= '0;
      rp <= '0;
      level <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        idx <= '0;
        hold <= '0;
      end else if (enin) begin
        idx <= idx + 2'd1;
        hold <= word[23:0];
      end
      if (acc) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      if (acc && !pop) level <= level + LW'(1);
      else if (pop && !acc) level <= level - LW'(1);
      overflow <= (push && !acc) ? 1'b1 : (ovf_clr ? 1'b0 : overflow);
    end
  always_ff @(posedge ck)
    if (acc) begin
      mem_d[wp] <= word;
      mem_k[wp] <= keep;
    end
`ifdef BYTE_PACKER_PARITY_EN
  logic [3:0] par;
  logic [3:0] mem_p [DEPTH];
  always_comb
    for (int i = 0; i < 4; i++) par[i] = ^word[i*8 +: 8];
  always_ff @(posedge ck)
    if (acc) mem_p[wp] <= par;
  assign out_par = out_valid ? mem_p[rp] : '0;
`endif
endmodule

// File: tb/tb_byte_packer.sv
// tb_byte_packer: directed table vectors plus hand sequences for back-pressure, overflow and async reset.
module tb_byte_packer;
  logic ck = 0, rst_n = 0, enin = 0, flush = 0, ovf_clr = 0, out_ready = 0;
  logic [31:0] din = 0;
  logic out_valid, overflow;
  logic [31:0] out_data;
  logic [3:0] out_keep;
  logic [2:0] level;
`ifdef BYTE_PACKER_PARITY_EN
  logic [3:0] out_par;
`endif
  int checks = 0, failures = 0;

  byte_packer #(.DEPTH(4)) dut (
    .ck(ck), .rst_n(rst_n), .enin(enin), .din(din), .flush(flush), .ovf_clr(ovf_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_keep(out_keep),
`ifdef BYTE_PACKER_PARITY_EN
    .out_par(out_par),
`endif
    .level(level), .overflow(overflow)
  );

  always #5 ck = ~ck;

  typedef struct {
    logic en; logic [31:0] d; logic fl; logic rdy;
    logic v; logic [31:0] data; logic [3:0] keep; logic [2:0] lvl;
  } vec_t;
  vec_t tbl[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic byte_in(input logic [7:0] b);
    enin = 1; din = {24'hdead00, b};
    tick();
    enin = 0;
  endtask

  task automatic do_reset();
    rst_n = 0; #2; rst_n = 1;
    tick();
  endtask

  function automatic logic [31:0] wexp(input int w);
    return {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
  endfunction

  initial begin
    tbl[0]  = '{1, 32'h11,       0, 1, 0, 32'h0,        4'h0, 3'd0};
    tbl[1]  = '{1, 32'h22,       0, 1, 0, 32'h0,        4'h0, 3'd0};
    tbl[2]  = '{1, 32'h33,       0, 1, 0, 32'h0,        4'h0, 3'd0};
    tbl[3]  = '{1, 32'h44,       0, 1, 1, 32'h44332211, 4'hf, 3'd1};
    tbl[4]  = '{0, 32'h0,        0, 1, 0, 32'h0,        4'h0, 3'd0};
    tbl[5]  = '{1, 32'hFFFFFF01, 0, 1, 0, 32'h0,        4'h0, 3'd0};
    tbl[6]  = '{1, 32'hAB000002, 0, 1, 0, 32'h0,        4'h0, 3'd0};
    tbl[7]  = '{1, 32'h3,        0, 1, 0, 32'h0,        4'h0, 3'd0};
    tbl[8]  = '{1, 32'h4,        0, 1, 1, 32'h04030201, 4'hf, 3'd1};
    tbl[9]  = '{1, 32'hA1,       0, 1, 0, 32'h0,        4'h0, 3'd0};
    tbl[10] = '{1, 32'hA2,       0, 1, 0, 32'h0,        4'h0, 3'd0};
    tbl[11] = '{0, 32'h0,        1, 1, 1, 32'h0000A2A1, 4'h3, 3'd1};
    tbl[12] = '{1, 32'hB1,       0, 1, 0, 32'h0,        4'h0, 3'd0};
    tbl[13] = '{1, 32'hB2,       0, 1, 0, 32'h0,        4'h0, 3'd0};
    tbl[14] = '{1, 32'hB3,       0, 1, 0, 32'h0,        4'h0, 3'd0};
    tbl[15] = '{1, 32'hB4,       1, 1, 1, 32'hB4B3B2B1, 4'hf, 3'd1};
    tbl[16] = '{0, 32'h0,        0, 1, 0, 32'h0,        4'h0, 3'd0};
    tbl[17] = '{0, 32'h0,        1, 1, 0, 32'h0,        4'h0, 3'd0};
    tbl[18] = '{1, 32'hC5,       1, 1, 1, 32'h000000C5, 4'h1, 3'd1};
    tbl[19] = '{0, 32'h0,        0, 1, 0, 32'h0,        4'h0, 3'd0};

    #3;
    chk("reset_valid", 32'(out_valid), 0);
    chk("reset_data", out_data, 0);
    chk("reset_keep", 32'(out_keep), 0);
    chk("reset_level", 32'(level), 0);
    chk("reset_ovf", 32'(overflow), 0);
    do_reset();

    for (int i = 0; i < 20; i++) begin
      enin = tbl[i].en; din = tbl[i].d; flush = tbl[i].fl; out_ready = tbl[i].rdy;
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tbl[i].v));
      chk($sformatf("vec%0d_data", i), out_data, tbl[i].data);
      chk($sformatf("vec%0d_keep", i), 32'(out_keep), 32'(tbl[i].keep));
      chk($sformatf("vec%0d_level", i), 32'(level), 32'(tbl[i].lvl));
    end
    enin = 0; flush = 0;

    // back-pressure: 20 bytes with sink stalled, fifth word dropped
    out_ready = 0;
    for (int k = 0; k < 16; k++) byte_in(8'(k));
    chk("bp_level16", 32'(level), 4);
    chk("bp_ovf16", 32'(overflow), 0);
    for (int k = 16; k < 20; k++) byte_in(8'(k));
    chk("bp_level20", 32'(level), 4);
    chk("bp_ovf20", 32'(overflow), 1);
    chk("bp_head_stable", out_data, wexp(0));
    out_ready = 1;
    for (int w = 0; w < 4; w++) begin
      chk($sformatf("drain%0d_data", w), out_data, wexp(w));
      chk($sformatf("drain%0d_valid", w), 32'(out_valid), 1);
      tick();
    end
    chk("drain_level", 32'(level), 0);
    chk("drain_ovf_sticky", 32'(overflow), 1);
    ovf_clr = 1; tick(); ovf_clr = 0;
    chk("ovf_cleared", 32'(overflow), 0);

    // full FIFO: completing a word while popping is accepted
    out_ready = 0;
    for (int k = 0; k < 19; k++) byte_in(8'(k));
    chk("fp_level_pre", 32'(level), 4);
    out_ready = 1;
    byte_in(8'd19);
    out_ready = 0;
    chk("fp_level", 32'(level), 4);
    chk("fp_ovf", 32'(overflow), 0);
    out_ready = 1;
    for (int w = 1; w < 5; w++) begin
      chk($sformatf("fp_drain%0d", w), out_data, wexp(w));
      tick();
    end
    chk("fp_empty", 32'(level), 0);

    // async reset mid-word with a word queued
    out_ready = 0;
    for (int k = 0; k < 6; k++) byte_in(8'(k));
    chk("ar_level_pre", 32'(level), 1);
    #2 rst_n = 0; #1;
    chk("ar_valid", 32'(out_valid), 0);
    chk("ar_data", out_data, 0);
    chk("ar_keep", 32'(out_keep), 0);
    chk("ar_level", 32'(level), 0);
    #1 rst_n = 1;
    tick();
    out_ready = 1;
    byte_in(8'h5); byte_in(8'h6); byte_in(8'h7); byte_in(8'h8);
    chk("ar_word", out_data, 32'h08070605);
    chk("ar_word_keep", 32'(out_keep), 4'hf);
    chk("ar_word_valid", 32'(out_valid), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
